// File: rtl/cpu_pipe_pkg.sv
// Shared decode/execute payload layout and NOP encodings for the pipeline stage registers.
package cpu_pipe_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned REG_W     = 4;
  localparam int unsigned ALUOP_W   = 4;
  localparam int unsigned CTRLB_W   = 2;
  localparam int unsigned JORB_W    = 2;
  localparam int unsigned CTRLMEM_W = 2;
  localparam int unsigned SPARE_W   = 3;
  localparam int unsigned OCC_W     = 2;

  localparam logic [REG_W-1:0]     REG_NONE  = 4'hF;
  localparam logic [ALUOP_W-1:0]   ALU_NOP   = 4'h1;
  localparam logic [CTRLB_W-1:0]   CTRLB_NOP = 2'b10;
  localparam logic [JORB_W-1:0]    JORB_NOP  = 2'b11;
  localparam logic [CTRLMEM_W-1:0] MEM_NOP   = 2'b11;
  localparam logic                 WB_NOP    = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0]    data_a;
    logic [DATA_W-1:0]    data_b;
    logic [DATA_W-1:0]    data_c;
    logic [DATA_W-1:0]    pc;
    logic [REG_W-1:0]     wreg;
    logic [ALUOP_W-1:0]   aluop;
    logic [CTRLB_W-1:0]   ctrlb;
    logic [JORB_W-1:0]    jorb;
    logic [CTRLMEM_W-1:0] mem;
    logic                 wb;
    logic [SPARE_W-1:0]   spare;
  } id_exe_t;

  localparam int unsigned ID_EXE_W = $bits(id_exe_t);

  // Bubble presented to execute: every control field at its NOP encoding.
  localparam id_exe_t ID_EXE_BUBBLE = '{
    data_a: '0, data_b: '0, data_c: '0, pc: '0,
    wreg: REG_NONE, aluop: ALU_NOP, ctrlb: CTRLB_NOP,
    jorb: JORB_NOP, mem: MEM_NOP, wb: WB_NOP, spare: '0
  };

endpackage

// File: rtl/pipe_stage_skid_if.sv
// One valid/ready/payload link between pipeline stages.
interface pipe_stage_skid_if #(
  parameter int unsigned W = 82
) ();
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// Single payload+valid holding register with clear-over-load priority.
module pipe_skid_slot #(
  parameter int unsigned   W      = 82,
  parameter logic [W-1:0]  BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register: main slot plus one-entry skid, flush to bubble, stall counter.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned          PAYLOAD_W = 82,
  parameter logic [PAYLOAD_W-1:0] BUBBLE    = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_skid_if.slave     up,
  pipe_stage_skid_if.master    dn,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [OCC_W-1:0]     occupancy
);

  logic                 r_in_ready;
  logic [OCC_W-1:0]     r_occ;
  logic [CNT_W-1:0]     r_stall;

  logic                 w_main_v, w_skid_v;
  logic [PAYLOAD_W-1:0] w_main_d, w_skid_d, w_main_din;
  logic                 w_acc, w_drn, w_main_ld;
  logic                 w_main_fill, w_main_clr, w_skid_fill, w_skid_clr;
  logic                 w_main_nxt, w_skid_nxt;

  assign w_acc     = up.valid & r_in_ready;
  assign w_drn     = w_main_v & dn.ready;
  assign w_main_ld = w_drn | ~w_main_v;

  // Main refills from skid first so ordering stays FIFO.
  assign w_main_fill = w_main_ld & (w_skid_v | w_acc);
  assign w_main_clr  = flush | (w_main_ld & ~w_skid_v & ~w_acc);
  assign w_main_din  = w_skid_v ? w_skid_d : up.data;
  assign w_skid_fill = w_acc & w_main_v & ~w_drn;
  assign w_skid_clr  = flush | (w_main_ld & w_skid_v);

  assign w_main_nxt = ~flush & (w_main_ld ? (w_skid_v | w_acc) : w_main_v);
  assign w_skid_nxt = ~flush & (w_skid_fill | (w_skid_v & ~w_main_ld));

  pipe_skid_slot #(.W(PAYLOAD_W), .BUBBLE(BUBBLE)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_fill),
    .i_clear (w_main_clr),
    .i_data  (w_main_din),
    .o_valid (w_main_v),
    .o_data  (w_main_d)
  );

  pipe_skid_slot #(.W(PAYLOAD_W), .BUBBLE(BUBBLE)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_fill),
    .i_clear (w_skid_clr),
    .i_data  (up.data),
    .o_valid (w_skid_v),
    .o_data  (w_skid_d)
  );

  // Ready, occupancy and stall count are registered from next-state slot flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_ready <= 1'b1;
      r_occ      <= '0;
      r_stall    <= '0;
    end else begin
      r_in_ready <= ~w_skid_nxt;
      r_occ      <= OCC_W'(w_main_nxt) + OCC_W'(w_skid_nxt);
      if (!flush && w_main_v && !dn.ready && (r_stall != {CNT_W{1'b1}}))
        r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign up.ready  = r_in_ready;
  assign dn.valid  = w_main_v;
  assign dn.data   = w_main_d;
  assign stall_cnt = r_stall;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;
  import cpu_pipe_pkg::*;

  localparam int unsigned PW = 82;
  localparam logic [PW-1:0] BUB = ID_EXE_BUBBLE;
  localparam int CNT_MAX = 65535;

  logic clk, rst, flush;
  logic [15:0] cnt;
  logic [1:0]  occ;
  logic [2:0]  cnt3;
  logic [1:0]  occ3;
  int checks, errors;

  pipe_stage_skid_if #(.W(PW)) up  ();
  pipe_stage_skid_if #(.W(PW)) dn  ();
  pipe_stage_skid_if #(.W(PW)) up3 ();
  pipe_stage_skid_if #(.W(PW)) dn3 ();

  pipe_stage_skid #(.PAYLOAD_W(PW), .BUBBLE(BUB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .up(up), .dn(dn),
    .stall_cnt(cnt), .occupancy(occ)
  );

  pipe_stage_skid #(.PAYLOAD_W(PW), .BUBBLE('0), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .up(up3), .dn(dn3),
    .stall_cnt(cnt3), .occupancy(occ3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    return PW'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0;
    up.valid = 1'b0; dn.ready = 1'b1; up3.valid = 1'b0; dn3.ready = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0;
    up.valid = 1'b1; up.data = 82'h5; dn.ready = 1'b0;
    tick(); tick();
    checks++;
    if ({dn.valid, up.ready, occ, cnt} !== {1'b0, 1'b1, 2'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_ctl got v=%0b r=%0b occ=%0d cnt=%0d exp v=0 r=1 occ=0 cnt=0",
               dn.valid, up.ready, occ, cnt);
    end
    checks++;
    if (dn.data !== BUB) begin
      errors++;
      $display("FAIL reset_data got %h exp %h", dn.data, BUB);
    end
    up.valid = 1'b0; dn.ready = 1'b1; rst = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [PW-1:0] pl;
    do_reset();
    dn.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pl = rnd_pl();
      up.valid = 1'b1; up.data = pl;
      tick();
      checks++;
      if ({dn.valid, dn.data, up.ready, cnt} !== {1'b1, pl, 1'b1, 16'd0}) begin
        errors++;
        $display("FAIL stream_%0d got v=%0b d=%h r=%0b cnt=%0d exp v=1 d=%h r=1 cnt=0",
                 i, dn.valid, dn.data, up.ready, cnt, pl);
      end
    end
    up.valid = 1'b0;
    tick();
    checks++;
    if ({dn.valid, dn.data, occ} !== {1'b0, BUB, 2'd0}) begin
      errors++;
      $display("FAIL stream_drain got v=%0b d=%h occ=%0d exp v=0 bubble occ=0", dn.valid, dn.data, occ);
    end
  endtask

  task automatic test_stall();
    logic [PW-1:0] a, b;
    a = rnd_pl(); b = rnd_pl();
    do_reset();
    dn.ready = 1'b0;
    up.valid = 1'b1; up.data = a; tick();
    up.data = b; tick();
    up.valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({dn.valid, dn.data, occ, up.ready, cnt} !== {1'b1, a, 2'd2, 1'b0, 16'(k)}) begin
        errors++;
        $display("FAIL stall_%0d got d=%h occ=%0d r=%0b cnt=%0d exp d=%h occ=2 r=0 cnt=%0d",
                 k, dn.data, occ, up.ready, cnt, a, k);
      end
      if (k < 4) tick();
    end
    dn.ready = 1'b1;
    tick();
    checks++;
    if ({dn.valid, dn.data, occ, up.ready, cnt} !== {1'b1, b, 2'd1, 1'b1, 16'd4}) begin
      errors++;
      $display("FAIL stall_release got d=%h occ=%0d r=%0b cnt=%0d exp d=%h occ=1 r=1 cnt=4",
               dn.data, occ, up.ready, cnt, b);
    end
    tick();
    checks++;
    if ({dn.valid, occ} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL stall_empty got v=%0b occ=%0d exp v=0 occ=0", dn.valid, occ);
    end
  endtask

  task automatic test_flush();
    do_reset();
    dn.ready = 1'b0;
    up.valid = 1'b1; up.data = rnd_pl(); tick();
    up.data = rnd_pl(); tick();
    flush = 1'b1; up.data = rnd_pl();
    tick();
    flush = 1'b0; up.valid = 1'b0;
    checks++;
    if ({dn.valid, dn.data, occ, up.ready, cnt} !== {1'b0, BUB, 2'd0, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL flush_full got v=%0b d=%h occ=%0d r=%0b cnt=%0d exp v=0 bubble occ=0 r=1 cnt=1",
               dn.valid, dn.data, occ, up.ready, cnt);
    end
    dn.ready = 1'b1;
    tick();
    checks++;
    if ({dn.valid, occ} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL flush_drop got v=%0b occ=%0d exp v=0 occ=0", dn.valid, occ);
    end
    // Empty stage with in_ready=1: the flush-cycle input still vanishes.
    flush = 1'b1; up.valid = 1'b1; up.data = rnd_pl();
    tick();
    flush = 1'b0; up.valid = 1'b0;
    checks++;
    if ({dn.valid, dn.data, occ} !== {1'b0, BUB, 2'd0}) begin
      errors++;
      $display("FAIL flush_empty got v=%0b d=%h occ=%0d exp v=0 bubble occ=0", dn.valid, dn.data, occ);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    dn3.ready = 1'b0;
    up3.valid = 1'b1; up3.data = rnd_pl(); tick();
    up3.valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (cnt3 !== 3'((k < 7) ? k : 7)) begin
        errors++;
        $display("FAIL sat_%0d got cnt=%0d exp %0d", k, cnt3, (k < 7) ? k : 7);
      end
    end
    rst = 1'b0; tick(); rst = 1'b1;
    checks++;
    if ({cnt3, dn3.valid, occ3} !== {3'd0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL sat_reset got cnt=%0d v=%0b occ=%0d exp 0 0 0", cnt3, dn3.valid, occ3);
    end
    dn3.ready = 1'b1;
  endtask

  task automatic test_rst_flush_acc();
    logic [PW-1:0] e;
    e = rnd_pl();
    do_reset();
    dn.ready = 1'b1;
    rst = 1'b0; flush = 1'b1; up.valid = 1'b1; up.data = e;
    tick();
    checks++;
    if ({dn.valid, dn.data, occ, up.ready, cnt} !== {1'b0, BUB, 2'd0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL rstflush got v=%0b d=%h occ=%0d r=%0b cnt=%0d exp reset values",
               dn.valid, dn.data, occ, up.ready, cnt);
    end
    rst = 1'b1; flush = 1'b0;
    tick();
    up.valid = 1'b0;
    checks++;
    if ({dn.valid, dn.data, occ} !== {1'b1, e, 2'd1}) begin
      errors++;
      $display("FAIL rstflush_accept got v=%0b d=%h occ=%0d exp v=1 d=%h occ=1",
               dn.valid, dn.data, occ, e);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] mq[$];
    logic [PW-1:0] d, exp_d;
    int mcnt;
    bit i_rst, i_fl, i_v, i_r, drn, acc;
    do_reset();
    mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      i_rst = ($urandom_range(0, 59) != 0);
      i_fl  = ($urandom_range(0, 24) == 0);
      i_v   = ($urandom_range(0, 9) < 6);
      i_r   = ($urandom_range(0, 9) < 5);
      d     = rnd_pl();
      rst = i_rst; flush = i_fl; up.valid = i_v; up.data = d; dn.ready = i_r;
      if (!i_rst) begin
        mq.delete(); mcnt = 0;
      end else if (i_fl) begin
        mq.delete();
      end else begin
        drn = (mq.size() > 0) && i_r;
        acc = i_v && (mq.size() < 2);
        if ((mq.size() > 0) && !i_r && (mcnt < CNT_MAX)) mcnt++;
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
      tick();
      exp_d = (mq.size() > 0) ? mq[0] : BUB;
      checks++;
      if ({dn.valid, dn.data, up.ready, occ, cnt} !==
          {mq.size() > 0, exp_d, mq.size() < 2, 2'(mq.size()), 16'(mcnt)}) begin
        errors++;
        $display("FAIL rand_%0d got v=%0b d=%h r=%0b occ=%0d cnt=%0d exp v=%0b d=%h r=%0b occ=%0d cnt=%0d",
                 c, dn.valid, dn.data, up.ready, occ, cnt,
                 mq.size() > 0, exp_d, mq.size() < 2, mq.size(), mcnt);
      end
    end
    rst = 1'b1; flush = 1'b0; up.valid = 1'b0; dn.ready = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; flush = 1'b0;
    up.valid = 1'b0; up.data = '0; dn.ready = 1'b1;
    up3.valid = 1'b0; up3.data = '0; dn3.ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_saturate();
    test_rst_flush_acc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline stage register that replaces the fixed-field inter-stage latches between decode and execute, and later between other stages.
- Carries an opaque packed payload with valid/ready handshaking, a one-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall-cycle counter for performance debug.
- Decode packs its control and data fields into the payload; execute unpacks them.

Parameters:
- PAYLOAD_W, 82: width of the packed payload (16-bit data ×3 + pc + register ids + control fields).
- BUBBLE, 82'h0: payload value driven while the stage holds no valid instruction; integrators set NOP encodings here (wreg=4'hF, aluop=4'h1, etc.).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- flush  input  1  kill both stored entries this cycle (branch/jump clear).
- in_valid  input  1  upstream has a payload.
- in_data  input  PAYLOAD_W  upstream payload.
- in_ready  output  1  stage can accept; registered (equals ~skid_valid).
- out_valid  output  1  out_data holds a live instruction.
- out_data  output  PAYLOAD_W  registered payload; equals BUBBLE whenever out_valid=0.
- out_ready  input  1  downstream accepts; 0 is the legacy keep/stall.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.
- occupancy  output  2  number of stored entries (0..2).

Behaviour:
- All state updates on the rising edge of clk only; rst is sampled synchronously, active-low.
- Priority each edge: rst=0, then flush=1, then normal transfer.
- Reset values: out_valid=0, out_data=BUBBLE, skid_valid=0, skid_data=BUBBLE, in_ready=1, stall_cnt=0, occupancy=0.
- Flush:
  - Sets out_valid=0, out_data=BUBBLE, skid_valid=0.
  - Any input presented in the flush cycle is dropped, even if in_ready=1.
  - stall_cnt is held.
  - in_ready=1 from the next cycle.
- Accept: acc = in_valid & in_ready.
- Drain: drn = out_valid & out_ready.
- The main register loads when drn=1 or out_valid=0:
  - From skid if skid_valid=1; then skid_valid<=0.
  - Else from in_data if acc=1.
  - Else out_valid<=0 and out_data<=BUBBLE.
- The skid register loads in_data when acc=1, out_valid=1 and drn=0. in_ready then drops to 0 on the next cycle.
- Simultaneous acc and drn with skid empty: main loads in_data, so full throughput is 1 per cycle with no bubble.
- Simultaneous acc and drn with skid full: cannot occur, because in_ready=0.
- Latency is 1 cycle from acc to out_valid when empty; order is strictly FIFO (main before skid).
- occupancy = out_valid + skid_valid.
- stall_cnt increments when out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, and is cleared only by rst.
- Reset asserted mid-stall or with a full skid discards both entries, identical to power-up.
- out_ready=0 while out_valid=0 has no effect. The stage still fills main, then skid.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - Field widths: DATA_W=16, REG_W=4, ALUOP_W=4, CTRLB_W=2, JORB_W=2, CTRLMEM_W=2.
  - NOP constants: REG_NONE=4'hF, ALU_NOP=4'h1, CTRLB_NOP=2'b10, JORB_NOP=2'b11, MEM_NOP=2'b11, WB_NOP=1.
  - A packed id_exe payload typedef, and the BUBBLE constant built from these NOP fields.
- Sub-module pipe_skid_slot: one data+valid register with load/clear. It is instantiated twice (main, skid), and the top holds only steering and the counter.

Test Plan:
- rst=0 for 2 cycles with in_valid=1, in_data=82'h5 → out_valid=0, out_data=BUBBLE, in_ready=1, stall_cnt=0, occupancy=0.
- Stream A,B,C on consecutive cycles with out_ready=1 → outputs A,B,C on cycles 1,2,3, in_ready stays 1, stall_cnt=0.
- Send A, B with out_ready=0 for 5 cycles, then 1:
  - While stalled: out_data=A, occupancy=2, in_ready=0 from cycle 3, stall_cnt=4.
  - After release: A, then B, with no loss or duplication.
- Main=A and skid=B with out_ready=0; assert flush with in_valid=1, in_data=C:
  - Next cycle: out_valid=0, out_data=BUBBLE, occupancy=0, C dropped, in_ready=1.
- CNT_W=3, out_valid=1 and out_ready=0 for 10 cycles → stall_cnt saturates at 7; asserting rst=0 returns it to 0.
- rst=0 and flush=1 in the same cycle as acc → reset values result and no entry is stored; the payload is accepted only after rst=1.
